// File: rtl/color_blend_pipe_if.sv
// color_blend_pipe_if: pixel, control and status bundle for color_blend_pipe.
interface color_blend_pipe_if #(parameter int CH_WIDTH = 4, parameter int NUM_CH = 3);
  logic                         i_CEN;
  logic [NUM_CH*CH_WIDTH-1:0]   i_OBJPIXEL;
  logic [NUM_CH*CH_WIDTH-1:0]   i_TMPIXEL;
  logic                         i_TMEN;
  logic [1:0]                   i_BLENDMODE;
  logic                         i_OUTEN;
  logic                         i_FORCEWHITE;
  logic                         i_VALID;
  logic                         i_FADE_START;
  logic                         i_FADE_DIR;
  logic [NUM_CH*CH_WIDTH-1:0]   o_OUT;
  logic                         o_VALID;
  logic [NUM_CH-1:0]            o_CARRY;
  logic                         o_FADE_BUSY;
  logic                         o_FADE_DONE;
  logic [CH_WIDTH-1:0]          o_FADE_LEVEL;
  modport master (
    output i_CEN, i_OBJPIXEL, i_TMPIXEL, i_TMEN, i_BLENDMODE, i_OUTEN, i_FORCEWHITE,
           i_VALID, i_FADE_START, i_FADE_DIR,
    input  o_OUT, o_VALID, o_CARRY, o_FADE_BUSY, o_FADE_DONE, o_FADE_LEVEL
  );
  modport slave (
    input  i_CEN, i_OBJPIXEL, i_TMPIXEL, i_TMEN, i_BLENDMODE, i_OUTEN, i_FORCEWHITE,
           i_VALID, i_FADE_START, i_FADE_DIR,
    output o_OUT, o_VALID, o_CARRY, o_FADE_BUSY, o_FADE_DONE, o_FADE_LEVEL
  );
endinterface

// File: rtl/color_blend_pipe.sv
// color_blend_pipe: 2-stage multi-channel obj/tilemap blender with fade-to-black FSM.
// Define COLOR_BLEND_WRAP_EN to make add/subtract wrap instead of saturate.
module color_blend_pipe #(
  parameter int CH_WIDTH = 4,
  parameter int NUM_CH   = 3,
  parameter int FADE_DIV = 4
) (
  input  logic i_EMU_MCLK,
  input  logic i_EMU_RST_n,
  color_blend_pipe_if.slave bus
);
  localparam int PW = NUM_CH * CH_WIDTH;
  localparam int DW = $clog2(FADE_DIV + 1);
  localparam logic [CH_WIDTH-1:0] MAX = '1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FADE_DIV - 1);
  typedef enum logic {IDLE, RUN} state_t;
  // Returns {carry/borrow, channel result}
  function automatic logic [CH_WIDTH:0] blend(input logic [CH_WIDTH-1:0] a, b, input logic [1:0] m);
    logic [CH_WIDTH:0] s, d;
    s = {1'b0, a} + {1'b0, b};
    d = {1'b0, a} - {1'b0, b};
`ifdef COLOR_BLEND_WRAP_EN
    return m == 2'b01 ? s : m == 2'b10 ? d : m == 2'b11 ? {1'b0, s[CH_WIDTH:1]} : {1'b0, a};
`else
    return m == 2'b01 ? {s[CH_WIDTH], s[CH_WIDTH] ? MAX : s[CH_WIDTH-1:0]} :
           m == 2'b10 ? {d[CH_WIDTH], d[CH_WIDTH] ? {CH_WIDTH{1'b0}} : d[CH_WIDTH-1:0]} :
           m == 2'b11 ? {1'b0, s[CH_WIDTH:1]} : {1'b0, a};
`endif
  endfunction
  logic [PW-1:0]       pix1_q, pix1_d, out_q, out_d;
  logic [NUM_CH-1:0]   carry1_q, carry1_d, carry_q;
  logic                valid1_q, outen1_q, fw1_q, valid_q;
  state_t              state_q, state_d;
  logic                dir_q, dir_d, done_q, done_d;
  logic [DW-1:0]       div_q, div_d;
  logic [CH_WIDTH-1:0] level_q, level_d, end_lvl;
  always_comb begin
    pix1_d   = '0;
    carry1_d = '0;
    out_d    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      {carry1_d[c], pix1_d[c*CH_WIDTH +: CH_WIDTH]} = blend(bus.i_OBJPIXEL[c*CH_WIDTH +: CH_WIDTH],
          bus.i_TMEN ? bus.i_TMPIXEL[c*CH_WIDTH +: CH_WIDTH] : {CH_WIDTH{1'b0}}, bus.i_BLENDMODE);
      out_d[c*CH_WIDTH +: CH_WIDTH] = !outen1_q ? {CH_WIDTH{1'b0}} : fw1_q ? MAX :
          pix1_q[c*CH_WIDTH +: CH_WIDTH] > level_q ? pix1_q[c*CH_WIDTH +: CH_WIDTH] - level_q : {CH_WIDTH{1'b0}};
    end
  end
  assign end_lvl = dir_q ? MAX : '0;
  // A start in either state restarts from the current level; an end-level check precedes stepping
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    div_d   = div_q;
    level_d = level_q;
    done_d  = 1'b0;
    if (bus.i_FADE_START) begin
      state_d = RUN;
      dir_d   = bus.i_FADE_DIR;
      div_d   = '0;
    end else if (state_q == RUN) begin
      if (level_q == end_lvl) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (div_q == DIV_LAST) begin
        div_d   = '0;
        level_d = dir_q ? level_q + 1'b1 : level_q - 1'b1;
        state_d = level_d == end_lvl ? IDLE : RUN;
        done_d  = level_d == end_lvl;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      pix1_q   <= '0;
      carry1_q <= '0;
      valid1_q <= 1'b0;
      outen1_q <= 1'b0;
      fw1_q    <= 1'b0;
      out_q    <= '0;
      carry_q  <= '0;
      valid_q  <= 1'b0;
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      div_q    <= '0;
      level_q  <= '0;
      done_q   <= 1'b0;
    end else if (bus.i_CEN) begin
      pix1_q   <= pix1_d;
      carry1_q <= carry1_d;
      valid1_q <= bus.i_VALID;
      outen1_q <= bus.i_OUTEN;
      fw1_q    <= bus.i_FORCEWHITE;
      out_q    <= out_d;
      carry_q  <= carry1_q;
      valid_q  <= valid1_q;
      state_q  <= state_d;
      dir_q    <= dir_d;
      div_q    <= div_d;
      level_q  <= level_d;
      done_q   <= done_d;
    end
  end
  assign bus.o_OUT        = out_q;
  assign bus.o_VALID      = valid_q;
  assign bus.o_CARRY      = carry_q;
  assign bus.o_FADE_BUSY  = state_q == RUN;
  assign bus.o_FADE_DONE  = done_q;
  assign bus.o_FADE_LEVEL = level_q;
endmodule
